button_repeat: RTL and testbench
================================

Name: button_repeat

Overview:
- Consumes the clean, debounced level from a push-button debouncer and turns it into single-cycle command events: press, release, and typematic auto-repeat while the button is held.
- Sits between the button debouncers and the scope control logic (timebase/trigger-level step controls), so a held button steps a setting continuously.

Parameters:
- ACTIVE_LOW, 1, 1 = input level 0 means pressed; 0 = level 1 means pressed
- TICK_DIV, 50000, clock cycles per timing tick (1 ms at 50 MHz); must be >= 1
- DELAY_TICKS, 500, ticks from press to first repeat; must be >= 1
- RATE_TICKS, 100, ticks between subsequent repeats; must be >= 1

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- inp  in  1  debounced button level, synchronous to clock
- enable  in  1  1 = generate events; 0 = suppress events and hold FSM in IDLE
- press  out  1  one-cycle pulse on the inactive->active transition
- release  out  1  one-cycle pulse on the active->inactive transition
- repeat  out  1  one-cycle pulse per auto-repeat
- step  out  1  press OR repeat (registered, same cycle as the source pulse)
- held  out  1  registered active level (follows inp even when enable=0)
- long_held  out  1  high from the first repeat until release

Behaviour:
- Polarity: act = ACTIVE_LOW ? ~inp : inp. Register a_q <= act on every edge.
- Reset: a_q, all outputs, and all counters are 0; FSM goes to IDLE. A button held through reset produces press on the first edge after reset_n rises, if enable=1.
- Edge detection at edge E: rise = act & ~a_q; fall = ~act & a_q. All outputs are registered, so the pulse is visible in the cycle after E. Latency from inp change to pulse is 1 clock.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = (count == TICK_DIV-1). Cleared to 0 on rise. Runs only in DELAY and REPEAT.
- Tick counter: width clog2(max(DELAY_TICKS, RATE_TICKS)+1). Cleared on rise and on each repeat. Increments on tick.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE: on rise with enable=1, assert press and step, then go to DELAY.
  - DELAY: when tick occurs with tick counter == DELAY_TICKS-1, assert repeat and step, set long_held, clear the tick counter, then go to REPEAT.
  - REPEAT: when tick occurs with tick counter == RATE_TICKS-1, assert repeat and step, clear the tick counter, stay in REPEAT.
  - DELAY or REPEAT: on fall, assert release, clear long_held and counters, go to IDLE.
  - Resulting timing: first repeat comes DELAY_TICKS*TICK_DIV cycles after press; later repeats every RATE_TICKS*TICK_DIV cycles.
- Simultaneous events:
  - fall on the same edge a repeat is due: release wins; no repeat.
  - release and press are never asserted in the same cycle.
- Rapid toggling: press-release-press on consecutive edges yields one pulse per edge. No minimum spacing; the debouncer upstream guarantees it.
- enable:
  - enable=0: press, release, repeat, step, and long_held are forced to 0; FSM goes to IDLE and counters clear; held still tracks act.
  - enable rising while the button is held: no press; a fresh rise is required.
  - fall while enable=0: no release.
- Widths: counters saturate at no point; the compare-to-terminal value guarantees wrap-free operation.
- Asynchronous reset mid-repeat: immediate return to reset state; the next press restarts timing from zero.

Decomposition:
- Shared package: FSM state encoding (IDLE, DELAY, REPEAT) and a clog2-based width helper constant function. Both are reused by other control blocks.
- One sub-module: tick_prescaler (parameter TICK_DIV; ports clock, reset_n, clear, run, tick).

Test Plan:
Bench parameters: TICK_DIV=4, DELAY_TICKS=3, RATE_TICKS=2, ACTIVE_LOW=1, enable=1 unless stated.
- Short press: inp 1->0 for 5 cycles, then 1 -> press once, 1 cycle after the fall; release once, 1 cycle after the rise; repeat never; held high for 5 cycles.
- Long hold: inp=0 for 40 cycles -> press at t, repeats at t+12, t+20, t+28, t+36; step at t, t+12, t+20, t+28, t+36; long_held rises at t+12.
- Release coincident with due repeat: release on the edge of the t+20 repeat -> release asserted, repeat not asserted; FSM returns to IDLE and long_held falls.
- Enable gating: hold inp=0 with enable=0, then raise enable -> no press, no repeats; inp->1 then ->0 -> press, then repeat 12 cycles later.
- Reset mid-repeat: assert reset_n=0 at t+22 for 2 cycles while inp=0 -> all outputs 0 immediately; after deassert, press on the first edge; first repeat 12 cycles after that press.
- ACTIVE_LOW=0 instance: inp 0->1 -> press; inp 1->0 -> release; timing identical to the long-hold case.

Source files
------------

// File: rtl/button_repeat_pkg.sv
// button_repeat_pkg: shared FSM state encoding and counter-width helpers for button control blocks
//   btn_state_t : IDLE / DELAY / REPEAT typematic states
//   cnt_width   : bits needed to hold the values 0..n-1 (never less than 1)
//   max_int     : larger of two integers, for sizing shared counters
package button_repeat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_repeat_tick_prescaler.sv
// tick_prescaler: free-running divider producing a one-cycle tick every TICK_DIV clocks while running
//   i_clock   : system clock
//   i_reset_n : asynchronous active-low reset
//   i_clear   : synchronous clear of the divider count (has priority over run)
//   i_run     : count enable; the count holds while low
//   o_tick    : high during the last cycle of each TICK_DIV-cycle period (only while running)
module tick_prescaler
    import button_repeat_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);

    localparam int              CW   = cnt_width(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    assign o_tick = i_run && (r_count == LAST);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_run)
            r_count <= o_tick ? '0 : r_count + 1'b1;
    end

endmodule

// File: rtl/button_repeat.sv
// button_repeat: turns a debounced button level into press/release/typematic-repeat command pulses
//   i_clock     : system clock, rising edge
//   i_reset_n   : asynchronous active-low reset
//   i_inp       : debounced button level (polarity set by ACTIVE_LOW)
//   i_enable    : 1 = generate events, 0 = suppress events and park the FSM in IDLE
//   o_press     : one-cycle pulse on inactive->active
//   o_release   : one-cycle pulse on active->inactive (only after a reported press)
//   o_repeat    : one-cycle pulse per auto-repeat
//   o_step      : press OR repeat
//   o_held      : registered active level, tracks the button regardless of enable
//   o_long_held : high from the first repeat until release
module button_repeat
    import button_repeat_pkg::*;
#(
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int TICK_DIV    = 50000,
    parameter int DELAY_TICKS = 500,
    parameter int RATE_TICKS  = 100
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_inp,
    input  logic i_enable,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_step,
    output logic o_held,
    output logic o_long_held
);

    localparam int            TW         = cnt_width(max_int(DELAY_TICKS, RATE_TICKS) + 1);
    localparam logic [TW-1:0] DELAY_LAST = TW'(DELAY_TICKS - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(RATE_TICKS - 1);

    logic       w_act, w_rise, w_fall, w_tick, w_run, w_clear;
    logic       w_press, w_release, w_repeat;
    logic       r_a_q;
    logic       r_press, r_release, r_repeat, r_step, r_long_held;
    logic [TW-1:0] r_tcnt;
    btn_state_t r_state, w_state_d;

    assign w_act  = ACTIVE_LOW ? ~i_inp : i_inp;
    assign w_rise = w_act & ~r_a_q;
    assign w_fall = ~w_act & r_a_q;

    // Timing only advances while a press is being tracked; any edge or a
    // disable restarts the period so the next press times from zero.
    assign w_run   = (r_state != ST_IDLE);
    assign w_clear = w_rise | w_fall | ~i_enable;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_clear),
        .i_run     (w_run),
        .o_tick    (w_tick)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_d;
    end

    // Fall is tested before the repeat terminal count so a release landing
    // on a due repeat reports only the release.
    always_comb begin
        w_state_d = r_state;
        w_press   = 1'b0;
        w_release = 1'b0;
        w_repeat  = 1'b0;
        if (!i_enable) begin
            w_state_d = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_press   = 1'b1;
                        w_state_d = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (w_fall) begin
                        w_release = 1'b1;
                        w_state_d = ST_IDLE;
                    end else if (w_tick && r_tcnt == DELAY_LAST) begin
                        w_repeat  = 1'b1;
                        w_state_d = ST_REPEAT;
                    end
                end
                ST_REPEAT: begin
                    if (w_fall) begin
                        w_release = 1'b1;
                        w_state_d = ST_IDLE;
                    end else if (w_tick && r_tcnt == RATE_LAST) begin
                        w_repeat  = 1'b1;
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_tcnt <= '0;
        else if (w_clear || w_repeat)
            r_tcnt <= '0;
        else if (w_tick)
            r_tcnt <= r_tcnt + 1'b1;
    end

    // REPEAT is only entered through the first repeat and left on release or
    // disable, so long_held is exactly "next state is REPEAT".
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_a_q       <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_repeat    <= 1'b0;
            r_step      <= 1'b0;
            r_long_held <= 1'b0;
        end else begin
            r_a_q       <= w_act;
            r_press     <= w_press;
            r_release   <= w_release;
            r_repeat    <= w_repeat;
            r_step      <= w_press | w_repeat;
            r_long_held <= (w_state_d == ST_REPEAT);
        end
    end

    assign o_press     = r_press;
    assign o_release   = r_release;
    assign o_repeat    = r_repeat;
    assign o_step      = r_step;
    assign o_held      = r_a_q;
    assign o_long_held = r_long_held;

endmodule

// File: tb/tb_button_repeat.sv
// tb_button_repeat: directed scoreboard bench for button_repeat (active-low and active-high instances)
module tb_button_repeat;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, inp_l, inp_h;
    logic p_l, r_l, rp_l, s_l, h_l, lh_l;
    logic p_h, r_h, rp_h, s_h, h_h, lh_h;

    // The active-high instance sees the complementary level, so both must
    // produce identical event streams.
    assign inp_h = ~inp_l;

    button_repeat #(
        .ACTIVE_LOW(1'b1), .TICK_DIV(4), .DELAY_TICKS(3), .RATE_TICKS(2)
    ) dut_l (
        .i_clock(clk), .i_reset_n(rst_n), .i_inp(inp_l), .i_enable(en),
        .o_press(p_l), .o_release(r_l), .o_repeat(rp_l), .o_step(s_l),
        .o_held(h_l), .o_long_held(lh_l)
    );

    button_repeat #(
        .ACTIVE_LOW(1'b0), .TICK_DIV(4), .DELAY_TICKS(3), .RATE_TICKS(2)
    ) dut_h (
        .i_clock(clk), .i_reset_n(rst_n), .i_inp(inp_h), .i_enable(en),
        .o_press(p_h), .o_release(r_h), .o_repeat(rp_h), .o_step(s_h),
        .o_held(h_h), .o_long_held(lh_h)
    );

    int n_run = 0;
    int n_fail = 0;
    logic [5:0] exp_q[$];

    // Packed as {press, release, repeat, step, held, long_held}
    function automatic logic [5:0] ev(input logic p, input logic r, input logic rp,
                                      input logic h, input logic lh);
        return {p, r, rp, p | rp, h, lh};
    endfunction

    task automatic check(input string tag);
        logic [5:0] e, ol, oh;
        e  = exp_q.pop_front();
        ol = {p_l, r_l, rp_l, s_l, h_l, lh_l};
        oh = {p_h, r_h, rp_h, s_h, h_h, lh_h};
        n_run++;
        assert (ol === e) else begin
            n_fail++;
            $error("FAIL %s lo: got %b want %b (press,rel,rep,step,held,long)", tag, ol, e);
        end
        n_run++;
        assert (oh === e) else begin
            n_fail++;
            $error("FAIL %s hi: got %b want %b (press,rel,rep,step,held,long)", tag, oh, e);
        end
    endtask

    task automatic cyc(input string tag, input logic iv, input logic en_v, input logic [5:0] e);
        @(negedge clk);
        inp_l = iv;
        en    = en_v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        inp_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(6'b0);
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("idle", 1'b1, 1'b1, 6'b0);

        for (int k = 0; k < 5; k++)
            cyc("short", 1'b0, 1'b1, ev(k == 0, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc("short_rel", 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("short_idle", 1'b1, 1'b1, 6'b0);

        for (int k = 0; k < 40; k++)
            cyc("hold", 1'b0, 1'b1,
                ev(k == 0, 1'b0, (k == 12 || k == 20 || k == 28 || k == 36), 1'b1, k >= 12));
        cyc("hold_rel", 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("hold_idle", 1'b1, 1'b1, 6'b0);

        for (int k = 0; k < 20; k++)
            cyc("coin", 1'b0, 1'b1, ev(k == 0, 1'b0, k == 12, 1'b1, k >= 12));
        cyc("coin_rel", 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++)
            cyc("coin_idle", 1'b1, 1'b1, 6'b0);

        for (int k = 0; k < 5; k++)
            cyc("en_off", 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 15; k++)
            cyc("en_on_held", 1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc("en_on_fall", 1'b1, 1'b1, 6'b0);
        for (int k = 0; k < 14; k++)
            cyc("en_fresh", 1'b0, 1'b1, ev(k == 0, 1'b0, k == 12, 1'b1, k >= 12));
        cyc("en_fresh_rel", 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

        for (int k = 0; k < 5; k++)
            cyc("dis_hold", 1'b0, 1'b1, ev(k == 0, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc("dis_mid", 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc("dis_fall", 1'b1, 1'b0, 6'b0);
        cyc("dis_reen", 1'b1, 1'b1, 6'b0);

        cyc("tog_p1", 1'b0, 1'b1, ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc("tog_r1", 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("tog_p2", 1'b0, 1'b1, ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc("tog_r2", 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

        for (int k = 0; k < 23; k++)
            cyc("pre_rst", 1'b0, 1'b1,
                ev(k == 0, 1'b0, (k == 12 || k == 20), 1'b1, k >= 12));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.push_back(6'b0);
        check("async_rst");
        cyc("in_rst", 1'b0, 1'b1, 6'b0);
        cyc("in_rst", 1'b0, 1'b1, 6'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++)
            cyc("post_rst", 1'b0, 1'b1, ev(k == 0, 1'b0, k == 12, 1'b1, k >= 12));
        cyc("post_rst_rel", 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("final_idle", 1'b1, 1'b1, 6'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
